// File: rtl/mmio_bus_arbiter_if.sv
// Signal bundle between two MMIO masters, the FPro controller and mmio_bus_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mmio_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              req_0, req_1;
  logic              wr_0, wr_1;
  logic              rd_0, rd_1;
  logic [ADDR_W-1:0] addr_0, addr_1;
  logic [DATA_W-1:0] wdata_0, wdata_1;
  logic              lock_0, lock_1;
  logic              busy_0, busy_1;
  logic              ack_0, ack_1;
  logic              err_0, err_1;
  logic [DATA_W-1:0] rdata_0, rdata_1;
  logic              mmio_cs, mmio_wr, mmio_rd;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wr_data;
  logic [DATA_W-1:0] mmio_rd_data;

  modport slave (
    input  req_0, req_1, wr_0, wr_1, rd_0, rd_1, addr_0, addr_1,
    input  wdata_0, wdata_1, lock_0, lock_1, mmio_rd_data,
    output busy_0, busy_1, ack_0, ack_1, err_0, err_1, rdata_0, rdata_1,
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );

  modport master (
    output req_0, req_1, wr_0, wr_1, rd_0, rd_1, addr_0, addr_1,
    output wdata_0, wdata_1, lock_0, lock_1, mmio_rd_data,
    input  busy_0, busy_1, ack_0, ack_1, err_0, err_1, rdata_0, rdata_1,
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter sharing one FPro MMIO bus: latched requests, round-robin with lock,
// one single-cycle bus transaction per grant. Define ARB_FIXED_PRIO_EN for master-0 priority.
module mmio_bus_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mmio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;

  state_e            state_q, state_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        pend_wr_q, pend_wr_d;
  logic [1:0]        pend_rd_q, pend_rd_d;
  logic [1:0]        pend_lock_q, pend_lock_d;
  logic [ADDR_W-1:0] pend_addr_q [2];
  logic [ADDR_W-1:0] pend_addr_d [2];
  logic [DATA_W-1:0] pend_wdata_q [2];
  logic [DATA_W-1:0] pend_wdata_d [2];
  logic              win_q, win_d;
  logic              illegal_q, illegal_d;
  logic              op_rd_q, op_rd_d;
  logic              op_lock_q, op_lock_d;
  logic              lock_valid_q, lock_valid_d;
  logic              lock_owner_q, lock_owner_d;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic              cs_q, cs_d;
  logic              mwr_q, mwr_d;
  logic              mrd_q, mrd_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic [1:0]        req_in, wr_in, rd_in, lock_in;
  logic [ADDR_W-1:0] addr_in [2];
  logic [DATA_W-1:0] wdata_in [2];
  logic              grant_valid, grant;

  assign req_in      = {bus.req_1, bus.req_0};
  assign wr_in       = {bus.wr_1, bus.wr_0};
  assign rd_in       = {bus.rd_1, bus.rd_0};
  assign lock_in     = {bus.lock_1, bus.lock_0};
  assign addr_in[0]  = bus.addr_0;
  assign addr_in[1]  = bus.addr_1;
  assign wdata_in[0] = bus.wdata_0;
  assign wdata_in[1] = bus.wdata_1;

  // A valid lock owner that has nothing pending keeps the bus idle until it releases.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (lock_valid_q) begin
      grant_valid = pend_q[lock_owner_q];
      grant       = lock_owner_q;
    end else if (&pend_q) begin
      grant_valid = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      grant       = 1'b0;
`else
      grant       = ~rr_last_q;
`endif
    end else if (pend_q[0]) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (pend_q[1]) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_wr_d    = pend_wr_q;
    pend_rd_d    = pend_rd_q;
    pend_lock_d  = pend_lock_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    win_d        = win_q;
    illegal_d    = illegal_q;
    op_rd_d      = op_rd_q;
    op_lock_d    = op_lock_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    rr_last_d    = rr_last_q;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = rdata_q;
    cs_d         = cs_q;
    mwr_d        = mwr_q;
    mrd_d        = mrd_q;
    maddr_d      = maddr_q;
    mwdata_d     = mwdata_q;

    // A slot is busy until its ACK cycle ends, so capture never races the clear below.
    for (int unsigned i = 0; i < 2; i++) begin
      if (req_in[i] && !pend_q[i]) begin
        pend_d[i]       = 1'b1;
        pend_wr_d[i]    = wr_in[i];
        pend_rd_d[i]    = rd_in[i];
        pend_lock_d[i]  = lock_in[i];
        pend_addr_d[i]  = addr_in[i];
        pend_wdata_d[i] = wdata_in[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          win_d     = grant;
          rr_last_d = grant;
          illegal_d = (pend_wr_q[grant] == pend_rd_q[grant]);
          op_rd_d   = pend_rd_q[grant];
          op_lock_d = pend_lock_q[grant];
          cs_d      = ~illegal_d;
          mwr_d     = ~illegal_d & pend_wr_q[grant];
          mrd_d     = ~illegal_d & pend_rd_q[grant];
          maddr_d   = illegal_d ? '0 : pend_addr_q[grant];
          mwdata_d  = illegal_d ? '0 : pend_wdata_q[grant];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cs_d         = 1'b0;
        mwr_d        = 1'b0;
        mrd_d        = 1'b0;
        maddr_d      = '0;
        mwdata_d     = '0;
        ack_d[win_q] = 1'b1;
        err_d[win_q] = illegal_q;
        if (!illegal_q && op_rd_q) rdata_d[win_q] = bus.mmio_rd_data;
        lock_valid_d = op_lock_q;
        lock_owner_d = win_q;
        state_d      = ACK;
      end
      ACK: begin
        pend_d[win_q] = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      pend_wr_q    <= '0;
      pend_rd_q    <= '0;
      pend_lock_q  <= '0;
      pend_addr_q  <= '{default: '0};
      pend_wdata_q <= '{default: '0};
      win_q        <= 1'b0;
      illegal_q    <= 1'b0;
      op_rd_q      <= 1'b0;
      op_lock_q    <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      rr_last_q    <= 1'b1;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '{default: '0};
      cs_q         <= 1'b0;
      mwr_q        <= 1'b0;
      mrd_q        <= 1'b0;
      maddr_q      <= '0;
      mwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_wr_q    <= pend_wr_d;
      pend_rd_q    <= pend_rd_d;
      pend_lock_q  <= pend_lock_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      win_q        <= win_d;
      illegal_q    <= illegal_d;
      op_rd_q      <= op_rd_d;
      op_lock_q    <= op_lock_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      rr_last_q    <= rr_last_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      cs_q         <= cs_d;
      mwr_q        <= mwr_d;
      mrd_q        <= mrd_d;
      maddr_q      <= maddr_d;
      mwdata_q     <= mwdata_d;
    end
  end

  assign bus.busy_0       = pend_q[0];
  assign bus.busy_1       = pend_q[1];
  assign bus.ack_0        = ack_q[0];
  assign bus.ack_1        = ack_q[1];
  assign bus.err_0        = err_q[0];
  assign bus.err_1        = err_q[1];
  assign bus.rdata_0      = rdata_q[0];
  assign bus.rdata_1      = rdata_q[1];
  assign bus.mmio_cs      = cs_q;
  assign bus.mmio_wr      = mwr_q;
  assign bus.mmio_rd      = mrd_q;
  assign bus.mmio_addr    = maddr_q;
  assign bus.mmio_wr_data = mwdata_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed self-checking bench for mmio_bus_arbiter with a simple combinational
// FPro controller model (addr 0x60 reads 0xA5, other addresses read 0xC0DE0000|addr).
module tb_mmio_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   viol = 0;

  int          ack_log[$];
  logic [20:0] bus_addr_log[$];
  logic [31:0] bus_wdata_log[$];

  mmio_bus_arbiter_if #(.ADDR_W(21), .DATA_W(32)) bus ();

  mmio_bus_arbiter #(.ADDR_W(21), .DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb
    bus.mmio_rd_data = (bus.mmio_addr == 21'h60) ? 32'h0000_00A5
                                                 : (32'hC0DE_0000 | {11'b0, bus.mmio_addr});

  always @(negedge clk) begin
    if (reset) begin
      if (bus.mmio_cs) begin
        bus_addr_log.push_back(bus.mmio_addr);
        bus_wdata_log.push_back(bus.mmio_wr_data);
      end
      if (bus.ack_0) ack_log.push_back(0);
      if (bus.ack_1) ack_log.push_back(1);
      if (bus.mmio_cs && (bus.mmio_wr == bus.mmio_rd)) viol++;
      if (!bus.mmio_cs && (bus.mmio_wr || bus.mmio_rd)) viol++;
      if (bus.ack_0 && bus.ack_1) viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
  endtask

  task automatic set_req(input int m, input logic w, input logic r, input logic [20:0] a,
                         input logic [31:0] d, input logic l);
    if (m == 0) begin
      bus.req_0 = 1'b1; bus.wr_0 = w; bus.rd_0 = r;
      bus.addr_0 = a; bus.wdata_0 = d; bus.lock_0 = l;
    end else begin
      bus.req_1 = 1'b1; bus.wr_1 = w; bus.rd_1 = r;
      bus.addr_1 = a; bus.wdata_1 = d; bus.lock_1 = l;
    end
  endtask

  task automatic wait_free(input int m);
    int n = 0;
    while (((m == 0) ? bus.busy_0 : bus.busy_1) && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("wait_free_m%0d", m), 64'(n < 40), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    ack_log.delete();
    bus_addr_log.delete();
    bus_wdata_log.delete();
  endtask

  function automatic logic [12:0] outs();
    return {bus.busy_0, bus.busy_1, bus.ack_0, bus.ack_1, bus.err_0, bus.err_1,
            bus.mmio_cs, bus.mmio_wr, bus.mmio_rd, |bus.mmio_addr, |bus.mmio_wr_data,
            |bus.rdata_0, |bus.rdata_1};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n0;
    int na;
    logic [31:0] prev;
    bus.req_0 = 0; bus.wr_0 = 0; bus.rd_0 = 0; bus.addr_0 = '0; bus.wdata_0 = '0; bus.lock_0 = 0;
    bus.req_1 = 0; bus.wr_1 = 0; bus.rd_1 = 0; bus.addr_1 = '0; bus.wdata_1 = '0; bus.lock_1 = 0;
    repeat (3) tick();
    chk("reset_outs", 64'(outs()), 64'd0);
    reset = 1'b1;
    tick();

    // single read, N..N+4 timing
    set_req(0, 0, 1, 21'h60, 32'h0, 0);
    tick();
    chk("rd_n1_busy_cs", {62'd0, bus.busy_0, bus.mmio_cs}, 64'b10);
    tick();
    chk("rd_n2_strobes", {61'd0, bus.mmio_cs, bus.mmio_wr, bus.mmio_rd}, 64'b101);
    chk("rd_n2_addr", 64'(bus.mmio_addr), 64'h60);
    chk("rd_n2_noack", 64'(bus.ack_0), 64'd0);
    tick();
    chk("rd_n3_ack_err", {62'd0, bus.ack_0, bus.err_0}, 64'b10);
    chk("rd_n3_rdata", 64'(bus.rdata_0), 64'hA5);
    chk("rd_n3_cs_off", 64'(bus.mmio_cs), 64'd0);
    tick();
    chk("rd_n4_busy_ack", {62'd0, bus.busy_0, bus.ack_0}, 64'b00);
    chk("rd_n4_rdata_held", 64'(bus.rdata_0), 64'hA5);
    chk("rd_one_cs", 64'(bus_addr_log.size()), 64'd1);

    // contention, two pairs of writes
    do_reset();
    chk("rst_rdata_clr", 64'(bus.rdata_0), 64'd0);
    set_req(0, 1, 0, 21'h100, 32'h1111_0000, 0);
    set_req(1, 1, 0, 21'h200, 32'h2222_0000, 0);
    tick();
    wait_free(0);
    wait_free(1);
    set_req(0, 1, 0, 21'h104, 32'h3333_0000, 0);
    set_req(1, 1, 0, 21'h204, 32'h4444_0000, 0);
    tick();
    wait_free(0);
    wait_free(1);
    chk("cont_nack", 64'(ack_log.size()), 64'd4);
    chk("cont_order", {60'd0, 1'(ack_log[0]), 1'(ack_log[1]), 1'(ack_log[2]), 1'(ack_log[3])},
        64'b0101);
    chk("cont_addr", {bus_addr_log[0], bus_addr_log[1], bus_addr_log[2]},
        {21'h100, 21'h200, 21'h104});
    chk("cont_wdata_a", {bus_wdata_log[0], bus_wdata_log[1]}, {32'h1111_0000, 32'h2222_0000});
    chk("cont_wdata_b", {bus_wdata_log[2], bus_wdata_log[3]}, {32'h3333_0000, 32'h4444_0000});

    // M0 alone, then both: round-robin now favours M1
    set_req(0, 1, 0, 21'h108, 32'h5, 0);
    tick();
    wait_free(0);
    set_req(0, 1, 0, 21'h10C, 32'h6, 0);
    set_req(1, 1, 0, 21'h20C, 32'h7, 0);
    tick();
    wait_free(0);
    wait_free(1);
    chk("rr_nack", 64'(ack_log.size()), 64'd7);
`ifdef ARB_FIXED_PRIO_EN
    chk("prio_order", {62'd0, 1'(ack_log[5]), 1'(ack_log[6])}, 64'b01);
`else
    chk("rr_order", {62'd0, 1'(ack_log[5]), 1'(ack_log[6])}, 64'b10);
`endif

    // lock: M1 keeps the bus across three writes while M0 read waits
    do_reset();
    set_req(1, 1, 0, 21'h210, 32'hAAAA_0001, 1);
    tick();
    set_req(0, 0, 1, 21'h300, 32'h0, 0);
    tick();
    wait_free(1);
    repeat (3) tick();
    chk("lock_hold_busy0", 64'(bus.busy_0), 64'd1);
    chk("lock_hold_nack", 64'(ack_log.size()), 64'd1);
    chk("lock_hold_ncs", 64'(bus_addr_log.size()), 64'd1);
    set_req(1, 1, 0, 21'h214, 32'hAAAA_0002, 1);
    tick();
    wait_free(1);
    repeat (2) tick();
    set_req(1, 1, 0, 21'h218, 32'hAAAA_0003, 0);
    tick();
    wait_free(1);
    wait_free(0);
    chk("lock_nack", 64'(ack_log.size()), 64'd4);
    chk("lock_order", {60'd0, 1'(ack_log[0]), 1'(ack_log[1]), 1'(ack_log[2]), 1'(ack_log[3])},
        64'b1110);
    chk("lock_addr", {bus_addr_log[0], bus_addr_log[1], bus_addr_log[2]},
        {21'h210, 21'h214, 21'h218});
    chk("lock_m0_addr", 64'(bus_addr_log[3]), 64'h300);
    chk("lock_m0_rdata", 64'(bus.rdata_0), 64'hC0DE_0300);

    // illegal ops: rd&wr on M0, neither on M1
    n0 = bus_addr_log.size();
    prev = bus.rdata_0;
    set_req(0, 1, 1, 21'h400, 32'h9, 0);
    tick(); tick(); tick();
    chk("ill0_ack_err", {62'd0, bus.ack_0, bus.err_0}, 64'b11);
    chk("ill0_rdata", 64'(bus.rdata_0), 64'(prev));
    tick();
    chk("ill0_err_clr", 64'(bus.err_0), 64'd0);
    set_req(1, 0, 0, 21'h404, 32'h0, 0);
    tick(); tick(); tick();
    chk("ill1_ack_err", {62'd0, bus.ack_1, bus.err_1}, 64'b11);
    chk("ill1_rdata", 64'(bus.rdata_1), 64'd0);
    tick();
    chk("ill_no_cs", 64'(bus_addr_log.size()), 64'(n0));

    // busy drop on M1
    n0 = bus_addr_log.size();
    na = ack_log.size();
    set_req(1, 1, 0, 21'h500, 32'h55, 0);
    tick();
    chk("drop_busy", 64'(bus.busy_1), 64'd1);
    set_req(1, 1, 0, 21'h600, 32'h66, 0);
    tick();
    set_req(1, 1, 0, 21'h604, 32'h67, 0);
    tick();
    wait_free(1);
    repeat (3) tick();
    chk("drop_ncs", 64'(bus_addr_log.size()), 64'(n0 + 1));
    chk("drop_addr", 64'(bus_addr_log[n0]), 64'h500);
    chk("drop_wdata", 64'(bus_wdata_log[n0]), 64'h55);
    chk("drop_nack", 64'(ack_log.size()), 64'(na + 1));

    // reset during ISSUE
    na = ack_log.size();
    set_req(0, 0, 1, 21'h60, 32'h0, 0);
    tick();
    tick();
    chk("rmid_issue", 64'(bus.mmio_cs), 64'd1);
    reset = 1'b0;
    tick();
    chk("rmid_outs", 64'(outs()), 64'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("rmid_noack", 64'(ack_log.size()), 64'(na));
    chk("rmid_idle", {62'd0, bus.busy_0, bus.busy_1}, 64'd0);
    set_req(0, 0, 1, 21'h60, 32'h0, 0);
    set_req(1, 1, 0, 21'h700, 32'h77, 0);
    tick();
    wait_free(0);
    wait_free(1);
    chk("rmid_order", {62'd0, 1'(ack_log[na]), 1'(ack_log[na + 1])}, 64'b01);
    chk("rmid_rdata", 64'(bus.rdata_0), 64'hA5);

    chk("no_overlap", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
